// File: rtl/ma_stage.sv
// rtl/ma_stage.sv - memory-access pipeline stage; MA_MISALIGN_CHK_EN enables the misaligned ld/st trap
package ma_stage_pkg;
    typedef struct packed {
        logic isLd;
        logic isSt;
        logic isWb;
        logic isCall;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] aluresult;
        logic [31:0] op2;
        ctrl_t       ctrl;
    } Ex_Ma_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] aluresult;
        logic [31:0] ld_data;
        ctrl_t       ctrl;
    } Ma_Wb_t;
endpackage

module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Ex_Valid_i,
    output logic              Ex_Ready_o,
    input  Ex_Ma_t            Ex_Payld_i,
    output logic              Ma_Valid_o,
    input  logic              Ma_Ready_i,
    output Ma_Wb_t            Ma_Payld_o,
    output logic              dmem_req_vld,
    input  logic              dmem_req_rdy,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [31:0]       dmem_req_wdata,
    input  logic              dmem_rsp_vld,
    input  logic [31:0]       dmem_rsp_rdata,
    output logic              misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t state;
    Ex_Ma_t hold;
    logic   accept;
    logic   is_mem;
    logic   misaligned;

    function automatic Ma_Wb_t to_wb(input Ex_Ma_t p, input logic [31:0] ld, input logic wb_en);
        Ma_Wb_t w;
        w.pc          = p.pc;
        w.instr       = p.instr;
        w.aluresult   = p.aluresult;
        w.ld_data     = ld;
        w.ctrl        = p.ctrl;
        w.ctrl.isWb   = p.ctrl.isWb & wb_en;
        return w;
    endfunction

    assign Ex_Ready_o = !Rst && (state == IDLE) && (!Ma_Valid_o || Ma_Ready_i);
    assign accept     = Ex_Valid_i && Ex_Ready_o;
    assign is_mem     = Ex_Payld_i.ctrl.isLd || Ex_Payld_i.ctrl.isSt;

    // Request lines come straight from the hold register, so they are stable for the whole REQ stall.
    assign dmem_req_vld   = (state == REQ);
    assign dmem_req_we    = hold.ctrl.isSt;
    assign dmem_req_addr  = {hold.aluresult[ADDR_W-1:2], 2'b00};
    assign dmem_req_wdata = hold.op2;

`ifdef MA_MISALIGN_CHK_EN
    assign misaligned = is_mem && (Ex_Payld_i.aluresult[1:0] != 2'b00);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            misalign_err <= 1'b0;
        else if (accept && misaligned)
            misalign_err <= 1'b1;
    end
`else
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            hold       <= '0;
            Ma_Valid_o <= 1'b0;
            Ma_Payld_o <= '0;
        end else begin
            // A drain clears valid unless a completion below re-asserts it in the same cycle.
            if (Ma_Ready_i)
                Ma_Valid_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        hold <= Ex_Payld_i;
                        if (misaligned) begin
                            Ma_Payld_o <= to_wb(Ex_Payld_i, 32'h0, 1'b0);
                            Ma_Valid_o <= 1'b1;
                        end else if (is_mem) begin
                            state <= REQ;
                        end else begin
                            Ma_Payld_o <= to_wb(Ex_Payld_i, 32'h0, 1'b1);
                            Ma_Valid_o <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_rdy) begin
                        if (hold.ctrl.isSt) begin
                            Ma_Payld_o <= to_wb(hold, 32'h0, 1'b1);
                            Ma_Valid_o <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (dmem_rsp_vld) begin
                        Ma_Payld_o <= to_wb(hold, dmem_rsp_rdata, 1'b1);
                        Ma_Valid_o <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
